// File: rtl/io_uart_fifo.sv
// Console UART with programmable baud divisor, parity/stop modes, RX/TX FIFOs and sticky errors.
// State | meaning: IDLE line idle / START start bit / DATA data bits / PARITY parity bit / STOP stop bit(s)
module io_uart_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int RX_DEPTH   = 16,
  parameter int TX_DEPTH   = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [DIV_WIDTH-1:0]      baud_div_i,
  input  logic                      parity_en_i,
  input  logic                      parity_odd_i,
  input  logic                      stop2_i,
  input  logic [DATA_BITS-1:0]      tx_data_i,
  input  logic                      tx_wr_i,
  input  logic                      rx_rd_i,
  input  logic                      err_clr_i,
  input  logic                      rxd_i,
  output logic                      txd_o,
  output logic [DATA_BITS-1:0]      rx_data_o,
  output logic                      da_n_o,
  output logic                      tbmt_n_o,
  output logic                      txemt_n_o,
  output logic                      parity_err_o,
  output logic                      framing_err_o,
  output logic                      overrun_o,
  output logic [$clog2(RX_DEPTH):0] rx_level_o,
  output logic [$clog2(TX_DEPTH):0] tx_level_o
);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [OSW-1:0] OS_MAX  = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [BCW-1:0] BIT_MAX = BCW'(DATA_BITS - 1);
  localparam logic [RXA:0]   RX_FULL = (RXA+1)'(RX_DEPTH);
  localparam logic [TXA:0]   TX_FULL = (TXA+1)'(TX_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  logic [DIV_WIDTH-1:0] tick_cnt_q;
  logic                 tick;
  assign tick = (tick_cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (reset_i)   tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= baud_div_i;
    else           tick_cnt_q <= tick_cnt_q - 1'b1;
  end

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TXA-1:0]       tx_wp_q, tx_rp_q;
  logic [TXA:0]         tx_cnt_q, tx_cnt_d;
  logic                 tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_push  = tx_wr_i && (tx_cnt_q != TX_FULL);
  assign tx_cnt_d = tx_cnt_q + (TXA+1)'(tx_push) - (TXA+1)'(tx_pop);
  assign tx_head  = tx_mem[tx_rp_q];

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wp_q] <= tx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // TX FSM
  state_e               tx_state_q, tx_state_d;
  logic [OSW-1:0]       tx_os_q, tx_os_d;
  logic [BCW-1:0]       tx_bit_q, tx_bit_d, stop_cnt;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d;

  assign stop_cnt = stop2_i ? BCW'(1) : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_state_q <= S_IDLE; tx_os_q <= '0; tx_bit_q <= '0; tx_sh_q <= '0; tx_par_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d; tx_os_q <= tx_os_d; tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d; tx_par_q <= tx_par_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_os_d    = tx_os_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    if (tick) begin
      if (tx_state_q != S_IDLE && tx_os_q != '0) tx_os_d = tx_os_q - 1'b1;
      else begin
        unique case (tx_state_q)
          S_IDLE:   ;
          S_START:  begin tx_os_d = OS_MAX; tx_bit_d = BIT_MAX; tx_state_d = S_DATA; end
          S_DATA: begin
            tx_os_d = OS_MAX;
            tx_sh_d = tx_sh_q >> 1;
            if (tx_bit_q == '0) begin
              tx_state_d = parity_en_i ? S_PARITY : S_STOP;
              tx_bit_d   = stop_cnt;
            end else tx_bit_d = tx_bit_q - 1'b1;
          end
          S_PARITY: begin tx_os_d = OS_MAX; tx_bit_d = stop_cnt; tx_state_d = S_STOP; end
          S_STOP: begin
            tx_os_d = OS_MAX;
            if (tx_bit_q != '0) tx_bit_d = tx_bit_q - 1'b1;
            else                tx_state_d = S_IDLE;
          end
          default:  tx_state_d = S_IDLE;
        endcase
      end
      // A pop from IDLE or at the end of the last stop bit starts the next frame with no gap.
      if (tx_pop) begin
        tx_state_d = S_START;
        tx_os_d    = OS_MAX;
        tx_sh_d    = tx_head;
        tx_par_d   = ^tx_head ^ parity_odd_i;
      end
    end
  end

  always_comb begin
    tx_pop = tick && (tx_cnt_q != '0) &&
             ((tx_state_q == S_IDLE) ||
              (tx_state_q == S_STOP && tx_os_q == '0 && tx_bit_q == '0));
    unique case (tx_state_q)
      S_START:  txd_o = 1'b0;
      S_DATA:   txd_o = tx_sh_q[0];
      S_PARITY: txd_o = tx_par_q;
      default:  txd_o = 1'b1;
    endcase
  end

  // RX synchroniser and FSM
  logic                 rxd_m_q, rxd_s_q, rxd_p_q, rx_fall;
  state_e               rx_state_q, rx_state_d;
  logic [OSW-1:0]       rx_os_q, rx_os_d;
  logic [BCW-1:0]       rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_push, perr_set, ferr_set, rx_smp;

  assign rx_fall = rxd_p_q && !rxd_s_q;
  assign rx_smp  = tick && (rx_os_q == '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rxd_m_q <= 1'b1; rxd_s_q <= 1'b1; rxd_p_q <= 1'b1;
      rx_state_q <= S_IDLE; rx_os_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0;
    end else begin
      rxd_m_q <= rxd_i; rxd_s_q <= rxd_m_q; rxd_p_q <= rxd_s_q;
      rx_state_q <= rx_state_d; rx_os_q <= rx_os_d; rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    if (rx_state_q == S_IDLE) begin
      if (rx_fall) begin rx_state_d = S_START; rx_os_d = OS_HALF; end
    end else if (tick && rx_os_q != '0) rx_os_d = rx_os_q - 1'b1;
    else if (rx_smp) begin
      rx_os_d = OS_MAX;
      unique case (rx_state_q)
        S_START: begin
          rx_state_d = rxd_s_q ? S_IDLE : S_DATA;
          rx_bit_d   = BIT_MAX;
        end
        S_DATA: begin
          rx_sh_d = {rxd_s_q, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bit_q == '0) rx_state_d = parity_en_i ? S_PARITY : S_STOP;
          else                rx_bit_d   = rx_bit_q - 1'b1;
        end
        S_PARITY: rx_state_d = S_STOP;
        default:  rx_state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_push  = rx_smp && (rx_state_q == S_STOP);
    perr_set = rx_smp && (rx_state_q == S_PARITY) && (rxd_s_q != (^rx_sh_q ^ parity_odd_i));
    ferr_set = rx_push && !rxd_s_q;
  end

  // RX FIFO; a push into a full FIFO succeeds only when a pop frees the head slot in the same cycle.
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [RXA-1:0]       rx_wp_q, rx_rp_q;
  logic [RXA:0]         rx_cnt_q, rx_cnt_d;
  logic                 rx_pop, rx_wr, ovr_set;

  assign rx_pop   = rx_rd_i && (rx_cnt_q != '0);
  assign rx_wr    = rx_push && ((rx_cnt_q != RX_FULL) || rx_pop);
  assign ovr_set  = rx_push && !rx_wr;
  assign rx_cnt_d = rx_cnt_q + (RXA+1)'(rx_wr) - (RXA+1)'(rx_pop);

  always_ff @(posedge clk_i) begin
    if (rx_wr) rx_mem[rx_wp_q] <= rx_sh_q;
  end

  logic da_n_q, tbmt_n_q, txemt_n_q, perr_q, ferr_q, ovr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
      da_n_q <= 1'b1; tbmt_n_q <= 1'b0; txemt_n_q <= 1'b0;
      perr_q <= 1'b0; ferr_q <= 1'b0; ovr_q <= 1'b0;
    end else begin
      if (rx_wr)  rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop) rx_rp_q <= rx_rp_q + 1'b1;
      rx_cnt_q  <= rx_cnt_d;
      da_n_q    <= (rx_cnt_d == '0);
      tbmt_n_q  <= (tx_cnt_d == TX_FULL);
      txemt_n_q <= !((tx_cnt_d == '0) && (tx_state_d == S_IDLE));
      perr_q    <= perr_set || (perr_q && !err_clr_i);
      ferr_q    <= ferr_set || (ferr_q && !err_clr_i);
      ovr_q     <= ovr_set  || (ovr_q  && !err_clr_i);
    end
  end

  assign rx_data_o     = (rx_cnt_q == '0) ? '0 : rx_mem[rx_rp_q];
  assign da_n_o        = da_n_q;
  assign tbmt_n_o      = tbmt_n_q;
  assign txemt_n_o     = txemt_n_q;
  assign parity_err_o  = perr_q;
  assign framing_err_o = ferr_q;
  assign overrun_o     = ovr_q;
  assign rx_level_o    = rx_cnt_q;
  assign tx_level_o    = tx_cnt_q;
endmodule

// File: tb/tb_io_uart_fifo.sv
// Bench for io_uart_fifo: directed serial checks plus randomized loopback against a queue scoreboard.
module tb_io_uart_fifo;
  localparam int OS = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, parity_en, parity_odd, stop2, tx_wr, err_clr;
  logic [15:0] baud_div;
  logic [7:0]  tx_data, rx_data;
  logic        rxd, txd, da_n, tbmt_n, txemt_n, perr, ferr, ovr, rx_rd;
  logic [4:0]  rx_level, tx_level;
  logic        loop_en = 1'b0, rxd_drv = 1'b1, rd_mon = 1'b0, rd_dir = 1'b0, mon_en = 1'b0;

  assign rxd   = loop_en ? txd : rxd_drv;
  assign rx_rd = rd_mon | rd_dir;

  io_uart_fifo dut (
    .clk_i(clk), .reset_i(reset), .baud_div_i(baud_div), .parity_en_i(parity_en),
    .parity_odd_i(parity_odd), .stop2_i(stop2), .tx_data_i(tx_data), .tx_wr_i(tx_wr),
    .rx_rd_i(rx_rd), .err_clr_i(err_clr), .rxd_i(rxd), .txd_o(txd), .rx_data_o(rx_data),
    .da_n_o(da_n), .tbmt_n_o(tbmt_n), .txemt_n_o(txemt_n), .parity_err_o(perr),
    .framing_err_o(ferr), .overrun_o(ovr), .rx_level_o(rx_level), .tx_level_o(tx_level)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: drains the RX FIFO whenever data is available.
  initial begin
    forever begin
      @(negedge clk);
      rd_mon = 1'b0;
      if (mon_en && !da_n) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rx_unexpected: got 0x%0h, expected no character", rx_data);
        end else chk("rx_data_sb", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        rd_mon = 1'b1;
      end
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_tx(input logic [7:0] d);
    tx_data = d; tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_val);
    int bl;
    bl = OS * (int'(baud_div) + 1);
    rxd_drv = 1'b0; repeat (bl) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rxd_drv = d[i]; repeat (bl) @(negedge clk); end
    rxd_drv = stop_val; repeat (bl) @(negedge clk);
    rxd_drv = 1'b1; repeat (bl) @(negedge clk);
  endtask

  task automatic read_one();
    rd_dir = 1'b1; @(negedge clk); rd_dir = 1'b0;
  endtask

  initial begin
    logic [9:0]  fr, s1, s8, s14;
    logic [7:0]  model[$];
    logic [7:0]  d;
    int          t, n;

    reset = 1'b1; baud_div = '0; parity_en = 0; parity_odd = 0; stop2 = 0;
    tx_data = '0; tx_wr = 0; err_clr = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_txd", txd, 1); chk("rst_da_n", da_n, 1); chk("rst_tbmt_n", tbmt_n, 0);
    chk("rst_txemt_n", txemt_n, 0); chk("rst_errs", {perr, ferr, ovr}, 0);
    chk("rst_rx_level", rx_level, 0); chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_data", rx_data, 0);

    // TX FIFO fill with a slow tick so nothing is popped; 17th write is ignored.
    baud_div = 16'd2000;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 17; i++) begin tx_data = 8'(i); tx_wr = 1'b1; @(negedge clk); end
    tx_wr = 1'b0;
    chk("txfull_level", tx_level, 16); chk("txfull_tbmt_n", tbmt_n, 1); chk("txfull_txd", txd, 1);
    baud_div = '0; reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
    chk("txfull_rst_level", tx_level, 0); chk("txfull_rst_tbmt_n", tbmt_n, 0);

    // 0x55 frame shape, 16 CLK per bit.
    write_tx(8'h55);
    t = 0;
    while (txd !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    chk("tx55_start_seen", t < 100, 1);
    fr = {1'b1, 8'h55, 1'b0};
    for (int off = 0; off < 160; off++) begin
      if (off % 16 == 1)  s1[off/16]  = txd;
      if (off % 16 == 8)  s8[off/16]  = txd;
      if (off % 16 == 14) s14[off/16] = txd;
      @(negedge clk);
    end
    for (int b = 0; b < 10; b++)
      chk($sformatf("tx55_bit%0d", b), {s1[b], s8[b], s14[b]}, {3{fr[b]}});
    repeat (3) @(negedge clk);
    chk("tx55_txemt_n", txemt_n, 0); chk("tx55_idle_txd", txd, 1);

    // Reset in the middle of a frame returns TXD high at once.
    write_tx(8'h00);
    repeat (40) @(negedge clk);
    chk("midrst_txd_low", txd, 0);
    reset = 1'b1; @(negedge clk);
    chk("midrst_txd", txd, 1); chk("midrst_txemt_n", txemt_n, 0);
    reset = 1'b0; @(negedge clk);

    // Odd parity loopback of 0xA3.
    parity_en = 1; parity_odd = 1; loop_en = 1'b1;
    write_tx(8'hA3);
    t = 0;
    while (da_n !== 1'b0 && t < 400) begin @(negedge clk); t++; end
    chk("a3_da_n", da_n, 0); chk("a3_rx_data", rx_data, 8'hA3);
    chk("a3_parity_err", perr, 0); chk("a3_level", rx_level, 1);
    repeat (20) @(negedge clk);
    read_one();
    chk("a3_drained", da_n, 1);

    // False start: 4 ticks low only.
    loop_en = 1'b0; parity_en = 0; parity_odd = 0;
    repeat (20) @(negedge clk);
    rxd_drv = 1'b0; repeat (4) @(negedge clk); rxd_drv = 1'b1;
    repeat (300) @(negedge clk);
    chk("fstart_da_n", da_n, 1); chk("fstart_level", rx_level, 0);

    // 17 characters without reads: reference FIFO model decides what survives.
    for (int i = 0; i < 17; i++) begin
      send_rx(8'(i), 1'b1);
      if (model.size() < DEPTH) model.push_back(8'(i));
    end
    chk("ovr_level", rx_level, model.size()); chk("ovr_flag", ovr, 1);
    chk("ovr_head", rx_data, model[0]);
    rd_dir = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("ovr_read%0d", i), rx_data, model.pop_front());
      @(negedge clk);
    end
    rd_dir = 1'b0;
    chk("ovr_empty_da_n", da_n, 1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
    chk("ovr_cleared", ovr, 0);

    // Stop bit low: character kept, framing error flagged until cleared.
    send_rx(8'h3C, 1'b0);
    chk("fe_rx_data", rx_data, 8'h3C); chk("fe_flag", ferr, 1); chk("fe_no_perr", perr, 0);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
    chk("fe_cleared", ferr, 0);
    read_one();

    // Randomized loopback batches checked by the scoreboard.
    loop_en = 1'b1; mon_en = 1'b1;
    for (int b = 0; b < 6; b++) begin
      baud_div   = 16'($urandom_range(0, 2));
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      stop2      = 1'($urandom_range(0, 1));
      repeat (4) @(negedge clk);
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        exp_q.push_back(d);
        write_tx(d);
      end
      t = 0;
      while ((exp_q.size() != 0 || txemt_n !== 1'b0) && t < 20000) begin @(negedge clk); t++; end
      chk($sformatf("rand%0d_drained", b), t < 20000, 1);
      repeat (OS * (int'(baud_div) + 1)) @(negedge clk);
      chk($sformatf("rand%0d_errs", b), {perr, ferr, ovr}, 0);
      exp_q.delete();
    end
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
